// File: rtl/gpio_ctrl_pkg.sv
// rtl/gpio_ctrl_pkg.sv - pad config bit offsets and drive-mode encodings
package gpio_ctrl_pkg;

  localparam int CFG_USED = 13;

  localparam int MGMT_EN = 0;
  localparam int OEB     = 1;
  localparam int HLDH    = 2;
  localparam int INP_DIS = 3;
  localparam int MOD_SEL = 4;
  localparam int AN_EN   = 5;
  localparam int AN_SEL  = 6;
  localparam int AN_POL  = 7;
  localparam int SLOW    = 8;
  localparam int TRIP    = 9;
  localparam int DM      = 10;

  localparam logic [2:0] DM_PULLUP   = 3'b010;
  localparam logic [2:0] DM_PULLDOWN = 3'b011;

  // Pull-up and pull-down share dm[2:1]; dm[0] picks the direction.
  function automatic logic is_pull_mode(input logic [2:0] dm);
    return dm[2:1] == DM_PULLUP[2:1];
  endfunction

endpackage

// File: rtl/gpio_ctrl_pad_mux.sv
// rtl/gpio_ctrl_pad_mux.sv - per-pad output mux and field decode for one GPIO pad
module gpio_ctrl_pad_mux
  import gpio_ctrl_pkg::*;
(
  input  logic [CFG_USED-1:0] cfg,
  input  logic                mgmt_gpio_out,
  input  logic                mgmt_gpio_oeb,
  input  logic                user_gpio_out,
  input  logic                user_gpio_oeb,
  input  logic                pad_gpio_in,
  output logic                mgmt_gpio_in,
  output logic                user_gpio_in,
  output logic                pad_gpio_holdover,
  output logic                pad_gpio_slow_sel,
  output logic                pad_gpio_vtrip_sel,
  output logic                pad_gpio_inenb,
  output logic                pad_gpio_ib_mode_sel,
  output logic                pad_gpio_ana_en,
  output logic                pad_gpio_ana_sel,
  output logic                pad_gpio_ana_pol,
  output logic                pad_gpio_outenb,
  output logic                pad_gpio_out,
  output logic [2:0]          pad_gpio_dm
);

  logic       gpio_logic1;
  logic       mgmt_ena;
  logic [2:0] dm;

  assign gpio_logic1 = 1'b1;
  assign mgmt_ena    = cfg[MGMT_EN];
  assign dm          = cfg[DM +: 3];

  assign mgmt_gpio_in         = pad_gpio_in;
  assign user_gpio_in         = pad_gpio_in & gpio_logic1;
  assign pad_gpio_holdover    = cfg[HLDH];
  assign pad_gpio_slow_sel    = cfg[SLOW];
  assign pad_gpio_vtrip_sel   = cfg[TRIP];
  assign pad_gpio_inenb       = cfg[INP_DIS];
  assign pad_gpio_ib_mode_sel = cfg[MOD_SEL];
  assign pad_gpio_ana_en      = cfg[AN_EN];
  assign pad_gpio_ana_sel     = cfg[AN_SEL];
  assign pad_gpio_ana_pol     = cfg[AN_POL];
  assign pad_gpio_dm          = dm;

  // In pull modes the output driver is off, so the out value steers the pull direction.
  always_comb begin
    pad_gpio_outenb = user_gpio_oeb;
    pad_gpio_out    = user_gpio_out;
    if (mgmt_ena) begin
      pad_gpio_outenb = mgmt_gpio_oeb ? cfg[OEB] : 1'b0;
      pad_gpio_out    = (mgmt_gpio_oeb && is_pull_mode(dm)) ? ~dm[0] : mgmt_gpio_out;
    end
  end

endmodule

// File: rtl/gpio_control_bank.sv
// rtl/gpio_control_bank.sv - multi-pad serial config segment; GPIO_CTRL_READBACK_EN enables config capture
module gpio_control_bank
  import gpio_ctrl_pkg::*;
#(
  parameter int NUM_PADS      = 2,
  parameter int PAD_CTRL_BITS = 13,
  localparam int CHAIN_LEN    = NUM_PADS * PAD_CTRL_BITS
) (
  input  logic                  serial_clock,
  input  logic                  resetn,
  input  logic [CHAIN_LEN-1:0]  gpio_defaults,
  input  logic                  serial_load,
  input  logic                  serial_capture,
  input  logic                  serial_data_in,
  output logic                  serial_data_out,
  output logic                  serial_clock_out,
  output logic                  resetn_out,
  output logic                  serial_load_out,
  output logic                  load_err,
  input  logic [NUM_PADS-1:0]   mgmt_gpio_out,
  input  logic [NUM_PADS-1:0]   mgmt_gpio_oeb,
  output logic [NUM_PADS-1:0]   mgmt_gpio_in,
  input  logic [NUM_PADS-1:0]   user_gpio_out,
  input  logic [NUM_PADS-1:0]   user_gpio_oeb,
  output logic [NUM_PADS-1:0]   user_gpio_in,
  output logic [NUM_PADS-1:0]   pad_gpio_holdover,
  output logic [NUM_PADS-1:0]   pad_gpio_slow_sel,
  output logic [NUM_PADS-1:0]   pad_gpio_vtrip_sel,
  output logic [NUM_PADS-1:0]   pad_gpio_inenb,
  output logic [NUM_PADS-1:0]   pad_gpio_ib_mode_sel,
  output logic [NUM_PADS-1:0]   pad_gpio_ana_en,
  output logic [NUM_PADS-1:0]   pad_gpio_ana_sel,
  output logic [NUM_PADS-1:0]   pad_gpio_ana_pol,
  output logic [NUM_PADS-1:0]   pad_gpio_outenb,
  output logic [NUM_PADS-1:0]   pad_gpio_out,
  output logic [3*NUM_PADS-1:0] pad_gpio_dm,
  input  logic [NUM_PADS-1:0]   pad_gpio_in
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);

  logic [CHAIN_LEN-1:0] shift_q, shift_d;
  logic [CHAIN_LEN-1:0] cfg_q, cfg_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 load_q, load_d;
  logic                 load_err_q, load_err_d;
  logic                 sdo_q, sdo_d;
  logic                 load_edge;

  assign serial_clock_out = serial_clock;
  assign resetn_out       = resetn;
  assign serial_load_out  = serial_load;
  assign serial_data_out  = sdo_q;
  assign load_err         = load_err_q;
  assign load_edge        = serial_load & ~load_q;

`ifndef GPIO_CTRL_READBACK_EN
  logic unused_capture;
  assign unused_capture = serial_capture;
`endif

  always_comb begin
    shift_d    = shift_q;
    cfg_d      = cfg_q;
    bit_cnt_d  = bit_cnt_q;
    load_err_d = load_err_q;
    load_d     = serial_load;
    sdo_d      = shift_q[CHAIN_LEN-1];
    // Only a load preceded by a complete local shift may update the pads.
    if (load_edge) begin
      bit_cnt_d = '0;
      if (bit_cnt_q == CNT_FULL) begin
        cfg_d      = shift_q;
        load_err_d = 1'b0;
      end else begin
        load_err_d = 1'b1;
      end
    end
`ifdef GPIO_CTRL_READBACK_EN
    else if (serial_capture) begin
      shift_d   = cfg_q;
      bit_cnt_d = '0;
    end
`endif
    else begin
      shift_d = {shift_q[CHAIN_LEN-2:0], serial_data_in};
      if (bit_cnt_q != CNT_FULL) bit_cnt_d = bit_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge serial_clock or negedge resetn) begin
    if (!resetn) begin
      shift_q    <= '0;
      cfg_q      <= gpio_defaults;
      bit_cnt_q  <= '0;
      load_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      cfg_q      <= cfg_d;
      bit_cnt_q  <= bit_cnt_d;
      load_q     <= load_d;
      load_err_q <= load_err_d;
    end
  end

  // Retimed on the falling edge so the next segment sees stable data on its rising edge.
  always_ff @(negedge serial_clock or negedge resetn) begin
    if (!resetn) sdo_q <= 1'b0;
    else         sdo_q <= sdo_d;
  end

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    gpio_ctrl_pad_mux u_pad_mux (
      .cfg                  (cfg_q[p*PAD_CTRL_BITS +: CFG_USED]),
      .mgmt_gpio_out        (mgmt_gpio_out[p]),
      .mgmt_gpio_oeb        (mgmt_gpio_oeb[p]),
      .user_gpio_out        (user_gpio_out[p]),
      .user_gpio_oeb        (user_gpio_oeb[p]),
      .pad_gpio_in          (pad_gpio_in[p]),
      .mgmt_gpio_in         (mgmt_gpio_in[p]),
      .user_gpio_in         (user_gpio_in[p]),
      .pad_gpio_holdover    (pad_gpio_holdover[p]),
      .pad_gpio_slow_sel    (pad_gpio_slow_sel[p]),
      .pad_gpio_vtrip_sel   (pad_gpio_vtrip_sel[p]),
      .pad_gpio_inenb       (pad_gpio_inenb[p]),
      .pad_gpio_ib_mode_sel (pad_gpio_ib_mode_sel[p]),
      .pad_gpio_ana_en      (pad_gpio_ana_en[p]),
      .pad_gpio_ana_sel     (pad_gpio_ana_sel[p]),
      .pad_gpio_ana_pol     (pad_gpio_ana_pol[p]),
      .pad_gpio_outenb      (pad_gpio_outenb[p]),
      .pad_gpio_out         (pad_gpio_out[p]),
      .pad_gpio_dm          (pad_gpio_dm[3*p +: 3])
    );
  end

endmodule

// File: tb/tb_gpio_control_bank.sv
// tb/tb_gpio_control_bank.sv - directed self-checking bench for gpio_control_bank
module tb_gpio_control_bank;

  logic        serial_clock;
  logic        resetn;
  logic [25:0] gpio_defaults;
  logic        serial_load;
  logic        serial_capture;
  logic        serial_data_in;
  logic        serial_data_out;
  logic        serial_clock_out;
  logic        resetn_out;
  logic        serial_load_out;
  logic        load_err;
  logic [1:0]  mgmt_gpio_out, mgmt_gpio_oeb, mgmt_gpio_in;
  logic [1:0]  user_gpio_out, user_gpio_oeb, user_gpio_in;
  logic [1:0]  pad_gpio_holdover, pad_gpio_slow_sel, pad_gpio_vtrip_sel, pad_gpio_inenb;
  logic [1:0]  pad_gpio_ib_mode_sel, pad_gpio_ana_en, pad_gpio_ana_sel, pad_gpio_ana_pol;
  logic [1:0]  pad_gpio_outenb, pad_gpio_out, pad_gpio_in;
  logic [5:0]  pad_gpio_dm;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [25:0] DEF = {13'h1801, 13'h0403};
  logic [25:0] PAT_A = {13'h1A5B, 13'h0B36};
  logic [25:0] PAT_B = {13'h04C7, 13'h1319};
  logic [25:0] PAT_Z = 26'h15A5A5A;

  logic [21:0] obs_fields;
  assign obs_fields = {pad_gpio_dm, pad_gpio_holdover, pad_gpio_slow_sel, pad_gpio_vtrip_sel,
                       pad_gpio_inenb, pad_gpio_ib_mode_sel, pad_gpio_ana_en, pad_gpio_ana_sel,
                       pad_gpio_ana_pol};

  gpio_control_bank dut (
    .serial_clock         (serial_clock),
    .resetn               (resetn),
    .gpio_defaults        (gpio_defaults),
    .serial_load          (serial_load),
    .serial_capture       (serial_capture),
    .serial_data_in       (serial_data_in),
    .serial_data_out      (serial_data_out),
    .serial_clock_out     (serial_clock_out),
    .resetn_out           (resetn_out),
    .serial_load_out      (serial_load_out),
    .load_err             (load_err),
    .mgmt_gpio_out        (mgmt_gpio_out),
    .mgmt_gpio_oeb        (mgmt_gpio_oeb),
    .mgmt_gpio_in         (mgmt_gpio_in),
    .user_gpio_out        (user_gpio_out),
    .user_gpio_oeb        (user_gpio_oeb),
    .user_gpio_in         (user_gpio_in),
    .pad_gpio_holdover    (pad_gpio_holdover),
    .pad_gpio_slow_sel    (pad_gpio_slow_sel),
    .pad_gpio_vtrip_sel   (pad_gpio_vtrip_sel),
    .pad_gpio_inenb       (pad_gpio_inenb),
    .pad_gpio_ib_mode_sel (pad_gpio_ib_mode_sel),
    .pad_gpio_ana_en      (pad_gpio_ana_en),
    .pad_gpio_ana_sel     (pad_gpio_ana_sel),
    .pad_gpio_ana_pol     (pad_gpio_ana_pol),
    .pad_gpio_outenb      (pad_gpio_outenb),
    .pad_gpio_out         (pad_gpio_out),
    .pad_gpio_dm          (pad_gpio_dm),
    .pad_gpio_in          (pad_gpio_in)
  );

  initial serial_clock = 1'b0;
  always #5 serial_clock = ~serial_clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [21:0] fields(input logic [25:0] w);
    logic [12:0] c0, c1;
    c0 = w[12:0];
    c1 = w[25:13];
    return {c1[12:10], c0[12:10], c1[2], c0[2], c1[8], c0[8], c1[9], c0[9], c1[3], c0[3],
            c1[4], c0[4], c1[5], c0[5], c1[6], c0[6], c1[7], c0[7]};
  endfunction

  task automatic tick;
    @(posedge serial_clock);
    #1;
  endtask

  task automatic shift_bits(input logic [25:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      serial_data_in = w[i];
      tick();
    end
  endtask

  task automatic pulse_load;
    serial_load = 1'b1;
    tick();
    serial_load = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    #12;
    total_cnt++;
    if (obs_fields !== fields(DEF)) $display("FAIL reset_fields: got %h expected %h", obs_fields, fields(DEF));
    else pass_cnt++;
    total_cnt++;
    if (pad_gpio_dm !== 6'b110001) $display("FAIL reset_dm: got %b expected 110001", pad_gpio_dm);
    else pass_cnt++;
    total_cnt++;
    if (pad_gpio_outenb !== 2'b01 || pad_gpio_out !== 2'b00)
      $display("FAIL reset_mux: got oeb=%b out=%b expected oeb=01 out=00", pad_gpio_outenb, pad_gpio_out);
    else pass_cnt++;
    total_cnt++;
    if (serial_data_out !== 1'b0 || load_err !== 1'b0 || resetn_out !== 1'b0)
      $display("FAIL reset_state: got sdo=%b err=%b rstout=%b expected 0 0 0", serial_data_out, load_err, resetn_out);
    else pass_cnt++;
    @(negedge serial_clock);
    resetn = 1'b1;
    #1;
    total_cnt++;
    if (serial_clock_out !== serial_clock || resetn_out !== 1'b1)
      $display("FAIL passthru: got clk_out=%b rst_out=%b expected %b 1", serial_clock_out, resetn_out, serial_clock);
    else pass_cnt++;
  endtask

  task automatic test_full_load;
    shift_bits(PAT_A, 26);
    pulse_load();
    total_cnt++;
    if (obs_fields !== fields(PAT_A)) $display("FAIL full_load_fields: got %h expected %h", obs_fields, fields(PAT_A));
    else pass_cnt++;
    total_cnt++;
    if (load_err !== 1'b0) $display("FAIL full_load_err: got %b expected 0", load_err);
    else pass_cnt++;
  endtask

  task automatic test_partial_load;
    shift_bits(PAT_B, 20);
    pulse_load();
    total_cnt++;
    if (obs_fields !== fields(PAT_A)) $display("FAIL partial_hold: got %h expected %h", obs_fields, fields(PAT_A));
    else pass_cnt++;
    total_cnt++;
    if (load_err !== 1'b1) $display("FAIL partial_err: got %b expected 1", load_err);
    else pass_cnt++;
    shift_bits(PAT_B, 26);
    pulse_load();
    total_cnt++;
    if (obs_fields !== fields(PAT_B) || load_err !== 1'b0)
      $display("FAIL reload: got %h err=%b expected %h err=0", obs_fields, load_err, fields(PAT_B));
    else pass_cnt++;
  endtask

  task automatic test_pad_mux;
    shift_bits({13'h0801, 13'h0C03}, 26);
    pulse_load();
    mgmt_gpio_oeb = 2'b11;
    mgmt_gpio_out = 2'b01;
    #1;
    total_cnt++;
    if (pad_gpio_out !== 2'b10 || pad_gpio_outenb !== 2'b01)
      $display("FAIL mux_pull: got out=%b oeb=%b expected out=10 oeb=01", pad_gpio_out, pad_gpio_outenb);
    else pass_cnt++;
    mgmt_gpio_oeb = 2'b00;
    #1;
    total_cnt++;
    if (pad_gpio_out !== 2'b01 || pad_gpio_outenb !== 2'b00)
      $display("FAIL mux_drive: got out=%b oeb=%b expected out=01 oeb=00", pad_gpio_out, pad_gpio_outenb);
    else pass_cnt++;
    shift_bits(26'h0, 26);
    pulse_load();
    user_gpio_oeb = 2'b10;
    user_gpio_out = 2'b01;
    pad_gpio_in   = 2'b11;
    #1;
    total_cnt++;
    if (pad_gpio_out !== 2'b01 || pad_gpio_outenb !== 2'b10)
      $display("FAIL mux_user: got out=%b oeb=%b expected out=01 oeb=10", pad_gpio_out, pad_gpio_outenb);
    else pass_cnt++;
    total_cnt++;
    if (user_gpio_in !== 2'b11 || mgmt_gpio_in !== 2'b11)
      $display("FAIL gpio_in: got user=%b mgmt=%b expected 11 11", user_gpio_in, mgmt_gpio_in);
    else pass_cnt++;
    pad_gpio_in = 2'b10;
    #1;
    total_cnt++;
    if (user_gpio_in !== 2'b10 || mgmt_gpio_in !== 2'b10)
      $display("FAIL gpio_in2: got user=%b mgmt=%b expected 10 10", user_gpio_in, mgmt_gpio_in);
    else pass_cnt++;
  endtask

  task automatic test_capture;
    logic [25:0] exp_stream;
    shift_bits(PAT_A, 26);
    pulse_load();
    shift_bits(PAT_Z, 26);
    serial_capture = 1'b1;
    serial_data_in = 1'b0;
    tick();
    serial_capture = 1'b0;
`ifdef GPIO_CTRL_READBACK_EN
    exp_stream = PAT_A;
`else
    exp_stream = {PAT_Z[24:0], 1'b0};
`endif
    for (int j = 0; j < 26; j++) begin
      @(negedge serial_clock);
      #1;
      total_cnt++;
      if (serial_data_out !== exp_stream[25-j])
        $display("FAIL stream_bit%0d: got %b expected %b", j, serial_data_out, exp_stream[25-j]);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (serial_data_out !== exp_stream[25-j])
        $display("FAIL stream_hold%0d: got %b expected %b", j, serial_data_out, exp_stream[25-j]);
      else pass_cnt++;
    end
    total_cnt++;
    if (obs_fields !== fields(PAT_A)) $display("FAIL capture_cfg: got %h expected %h", obs_fields, fields(PAT_A));
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    shift_bits(PAT_B, 26);
    serial_load = 1'b1;
    repeat (5) tick();
    serial_load = 1'b0;
    total_cnt++;
    if (obs_fields !== fields(PAT_B) || load_err !== 1'b0)
      $display("FAIL held_load: got %h err=%b expected %h err=0", obs_fields, load_err, fields(PAT_B));
    else pass_cnt++;
    shift_bits(PAT_A, 10);
    pulse_load();
    total_cnt++;
    if (load_err !== 1'b1) $display("FAIL pre_reset_err: got %b expected 1", load_err);
    else pass_cnt++;
    shift_bits(PAT_A, 7);
    #2;
    resetn = 1'b0;
    #1;
    total_cnt++;
    if (obs_fields !== fields(DEF) || load_err !== 1'b0 || serial_data_out !== 1'b0)
      $display("FAIL async_reset: got %h err=%b sdo=%b expected %h 0 0", obs_fields, load_err, serial_data_out, fields(DEF));
    else pass_cnt++;
    @(negedge serial_clock);
    resetn = 1'b1;
    shift_bits(PAT_A, 25);
    pulse_load();
    total_cnt++;
    if (obs_fields !== fields(DEF) || load_err !== 1'b1)
      $display("FAIL post_reset_short: got %h err=%b expected %h err=1", obs_fields, load_err, fields(DEF));
    else pass_cnt++;
    shift_bits(PAT_A, 26);
    pulse_load();
    total_cnt++;
    if (obs_fields !== fields(PAT_A) || load_err !== 1'b0)
      $display("FAIL post_reset_load: got %h err=%b expected %h err=0", obs_fields, load_err, fields(PAT_A));
    else pass_cnt++;
  endtask

  initial begin
    gpio_defaults  = DEF;
    serial_load    = 1'b0;
    serial_capture = 1'b0;
    serial_data_in = 1'b0;
    mgmt_gpio_out  = 2'b00;
    mgmt_gpio_oeb  = 2'b11;
    user_gpio_out  = 2'b00;
    user_gpio_oeb  = 2'b00;
    pad_gpio_in    = 2'b00;
    test_reset();
    test_full_load();
    test_partial_load();
    test_pad_mux();
    test_capture();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
